// File: rtl/vga_page_ctrl.sv
// vga_page_ctrl: frame-synchronous page scheduler selecting start/play/game-over colour source
`timescale 1ns/1ps
module vga_page_ctrl #(
  parameter int BLINK_FRAMES        = 30,
  parameter int OVER_TIMEOUT_FRAMES = 600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iFrame_start,
  input  logic       iKey_start,
  input  logic       iBall_lost,
  input  logic       iStart_R,
  input  logic       iStart_G,
  input  logic       iStart_B,
  input  logic       iGame_R,
  input  logic       iGame_G,
  input  logic       iGame_B,
  input  logic       iOver_R,
  input  logic       iOver_G,
  input  logic       iOver_B,
  output logic       oVGA_R,
  output logic       oVGA_G,
  output logic       oVGA_B,
  output logic [1:0] oPage,
  output logic       oGame_en,
  output logic       oGame_rst
);
  localparam int FW = OVER_TIMEOUT_FRAMES > 1 ? $clog2(OVER_TIMEOUT_FRAMES) : 1;
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FMAX = FW'(OVER_TIMEOUT_FRAMES - 1);
  localparam logic [BW-1:0] BMAX = BW'(BLINK_FRAMES - 1);
  localparam logic [1:0] S_START = 2'b00;
  localparam logic [1:0] S_PLAY  = 2'b01;
  localparam logic [1:0] S_OVER  = 2'b10;

  logic [1:0]    r_state, w_next;
  logic          r_key_q, r_pend, r_blink, r_game_rst;
  logic [FW-1:0] r_frame_cnt;
  logic [BW-1:0] r_blink_cnt;
  logic [2:0]    r_rgb, w_rgb;
  logic          w_key_ev, w_req, w_timeout, w_go;

  // Requests come from the key in START/OVER and from ball loss in PLAY; only applied at a frame boundary
  assign w_key_ev  = iKey_start & ~r_key_q;
  assign w_req     = (r_state == S_PLAY) ? iBall_lost : w_key_ev;
  assign w_timeout = (r_state == S_OVER) && (r_frame_cnt == FMAX);
  assign w_go      = iFrame_start & (r_pend | w_timeout);

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_START;
    else        r_state <= w_next;

  // Next state: each page has exactly one successor, taken only when w_go fires
  always_comb begin
    w_next = r_state;
    if (w_go) w_next = (r_state == S_START) ? S_PLAY : (r_state == S_PLAY) ? S_OVER : S_START;
  end

  // Outputs decoded from the state register; blink-off shows solid blue
  always_comb begin
    w_rgb    = (r_state == S_START) ? {iStart_R, iStart_G, iStart_B} :
               (r_state == S_PLAY)  ? {iGame_R, iGame_G, iGame_B} :
               (r_state == S_OVER)  ? (r_blink ? {iOver_R, iOver_G, iOver_B} : 3'b001) : 3'b000;
    oGame_en = (r_state == S_PLAY);
  end

  assign oPage = r_state;
  assign {oVGA_R, oVGA_G, oVGA_B} = r_rgb;
  assign oGame_rst = r_game_rst;

  // Key edge, pending flag, game reset pulse, colour register and game-over frame/blink counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_key_q     <= 1'b0;
      r_pend      <= 1'b0;
      r_game_rst  <= 1'b0;
      r_rgb       <= 3'b000;
      r_frame_cnt <= '0;
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else begin
      r_key_q    <= iKey_start;
      r_pend     <= w_go ? 1'b0 : (r_pend | w_req);
      r_game_rst <= w_go && (r_state == S_START);
      r_rgb      <= w_rgb;
      if (w_go && w_next == S_OVER) begin
        r_frame_cnt <= '0;
        r_blink_cnt <= '0;
        r_blink     <= 1'b1;
      end else if (r_state == S_OVER && iFrame_start && !w_go) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
        r_blink_cnt <= (r_blink_cnt == BMAX) ? '0 : r_blink_cnt + 1'b1;
        r_blink     <= (r_blink_cnt == BMAX) ? ~r_blink : r_blink;
      end
    end
endmodule
